// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU wait-state memory model.
package cpu_mem_pkg;

   localparam int unsigned MEM_DATA_WIDTH = 8;
   localparam int unsigned MEM_ADDR_WIDTH = 4;
   localparam int unsigned MEM_CNT_WIDTH  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/cpu_wait_memory_mem_array.sv
// DEPTH x DATA_WIDTH storage: two prioritised write ports, one registered read port.
module mem_array #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] waddr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] waddr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic                  re,
   input  logic                  rclr,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Port 0 is written last so it wins on an address collision.
   always_ff @(posedge clk) begin
      if (we1) mem_q[IDX_W'(waddr1)] <= wdata1;
      if (we0) mem_q[IDX_W'(waddr0)] <= wdata0;
   end

   // Read sees the array contents from before any same-edge write.
   always_ff @(posedge clk) begin
      if (rclr)    rdata_q <= '0;
      else if (re) rdata_q <= mem_q[IDX_W'(raddr)];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/cpu_wait_memory.sv
// CPU memory model with programmable wait states, ready pulse, sticky error and preload port.
module cpu_wait_memory
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = MEM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = MEM_ADDR_WIDTH,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] memoryIn,
   output logic [DATA_WIDTH-1:0] memoryOut,
   output logic                  ready,
   output logic                  err,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data
);

   localparam int unsigned       CNT_W   = MEM_CNT_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]  WAIT_L  = CNT_W'(WAIT_STATES);

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return ({1'b0, a} < DEPTH_L);
   endfunction

   mem_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic                  ready_q, ready_d;

   logic                  commit;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_data;
   logic                  cur_wr;
   logic                  cur_ok;
   logic                  cpu_we;
   logic                  rd_en;
   logic                  rd_zero;
   logic                  pre_we;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   // Next-state logic; commit marks the edge entering DONE, which with zero
   // wait states is the capture edge itself, so the live request is used then.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = wr_q;
      err_d    = err_q;
      commit   = 1'b0;
      cur_addr = addr_q;
      cur_data = data_q;
      cur_wr   = wr_q;

      unique case (state_q)
         IDLE: begin
            if (read | write) begin
               addr_d   = address;
               data_d   = memoryIn;
               wr_d     = write;
               cnt_d    = WAIT_L;
               cur_addr = address;
               cur_data = memoryIn;
               cur_wr   = write;
               if ((read & write) | !in_range(address)) err_d = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d = DONE;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = DONE;
               commit  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cur_ok  = in_range(cur_addr);
      cpu_we  = commit & cur_wr & cur_ok & ~clr;
      rd_en   = commit & ~cur_wr & cur_ok & ~clr;
      rd_zero = clr | (commit & ~cur_wr & ~cur_ok);
      ready_d = commit;
      pre_we  = load_en & in_range(load_addr);
   end

   mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk    (clk),
      .we0    (pre_we),
      .waddr0 (load_addr),
      .wdata0 (load_data),
      .we1    (cpu_we),
      .waddr1 (cur_addr),
      .wdata1 (cur_data),
      .re     (rd_en),
      .rclr   (rd_zero),
      .raddr  (cur_addr),
      .rdata  (memoryOut)
   );

   assign ready = ready_q;
   assign err   = err_q;

endmodule

// File: tb/tb_cpu_wait_memory.sv
// Directed bench: three memory instances (W=0/D=16, W=3/D=12, W=5/D=16).
module tb_cpu_wait_memory;

   logic       clk;
   logic       clr   [3];
   logic       rd    [3];
   logic       wr    [3];
   logic [3:0] ad    [3];
   logic [7:0] din   [3];
   logic [7:0] mo    [3];
   logic       rdy   [3];
   logic       er    [3];
   logic       ld_en [3];
   logic [3:0] ld_a  [3];
   logic [7:0] ld_d  [3];

   int n_cmp  = 0;
   int n_fail = 0;
   int lat;
   int hits;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cpu_wait_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_STATES(0)) u0 (
      .clk(clk), .clr(clr[0]), .read(rd[0]), .write(wr[0]), .address(ad[0]),
      .memoryIn(din[0]), .memoryOut(mo[0]), .ready(rdy[0]), .err(er[0]),
      .load_en(ld_en[0]), .load_addr(ld_a[0]), .load_data(ld_d[0]));

   cpu_wait_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .WAIT_STATES(3)) u3 (
      .clk(clk), .clr(clr[1]), .read(rd[1]), .write(wr[1]), .address(ad[1]),
      .memoryIn(din[1]), .memoryOut(mo[1]), .ready(rdy[1]), .err(er[1]),
      .load_en(ld_en[1]), .load_addr(ld_a[1]), .load_data(ld_d[1]));

   cpu_wait_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_STATES(5)) u5 (
      .clk(clk), .clr(clr[2]), .read(rd[2]), .write(wr[2]), .address(ad[2]),
      .memoryIn(din[2]), .memoryOut(mo[2]), .ready(rdy[2]), .err(er[2]),
      .load_en(ld_en[2]), .load_addr(ld_a[2]), .load_data(ld_d[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int k, input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en[k] = 1'b1;
      ld_a[k]  = a;
      ld_d[k]  = d;
      @(negedge clk);
      ld_en[k] = 1'b0;
   endtask

   // Present a request, hold it until ready is seen, then drop it in the ready cycle.
   task automatic xfer(input int k, input logic r, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input int exp_lat, input string tag);
      @(negedge clk);
      rd[k]  = r;
      wr[k]  = w;
      ad[k]  = a;
      din[k] = d;
      @(posedge clk);
      #1 ld_en[k] = 1'b0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (rdy[k]) break;
      end
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      @(negedge clk);
      chk({tag, "_ready_pulse"}, 32'(rdy[k]), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         clr[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; din[k] = '0;
         ld_en[k] = 1'b0; ld_a[k] = '0; ld_d[k] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) clr[k] = 1'b0;

      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_ready_%0d", k), 32'(rdy[k]), 32'd0);
         chk($sformatf("reset_mout_%0d", k), 32'(mo[k]), 32'd0);
         chk($sformatf("reset_err_%0d", k), 32'(er[k]), 32'd0);
      end

      // Zero wait states: preload then read back
      preload(0, 4'd7, 8'h03);
      xfer(0, 1'b1, 1'b0, 4'd7, 8'h00, 1, "w0_read7");
      chk("w0_read7_data", 32'(mo[0]), 32'h03);
      chk("w0_read7_err", 32'(er[0]), 32'd0);

      // Three wait states: read, write, read-after-write
      preload(1, 4'd0, 8'hC3);
      xfer(1, 1'b1, 1'b0, 4'd0, 8'h00, 4, "w3_read0");
      chk("w3_read0_data", 32'(mo[1]), 32'hC3);
      xfer(1, 1'b0, 1'b1, 4'd2, 8'h5A, 4, "w3_write2");
      chk("w3_write_keeps_mout", 32'(mo[1]), 32'hC3);
      xfer(1, 1'b1, 1'b0, 4'd2, 8'h00, 4, "w3_read2");
      chk("w3_read2_data", 32'(mo[1]), 32'h5A);
      chk("w3_err_clean", 32'(er[1]), 32'd0);

      // Out-of-range accesses on the 12-deep instance
      xfer(1, 1'b0, 1'b1, 4'd13, 8'h77, 4, "oor_write13");
      chk("oor_write_err", 32'(er[1]), 32'd1);
      xfer(1, 1'b1, 1'b0, 4'd13, 8'h00, 4, "oor_read13");
      chk("oor_read_zero", 32'(mo[1]), 32'h00);
      chk("oor_err_sticky", 32'(er[1]), 32'd1);
      xfer(1, 1'b1, 1'b0, 4'd2, 8'h00, 4, "oor_reread2");
      chk("oor_array_intact", 32'(mo[1]), 32'h5A);
      chk("oor_err_still", 32'(er[1]), 32'd1);
      @(negedge clk); clr[1] = 1'b1;
      @(negedge clk); clr[1] = 1'b0;
      chk("oor_err_cleared", 32'(er[1]), 32'd0);
      xfer(1, 1'b1, 1'b0, 4'd2, 8'h00, 4, "clr_keeps_array");
      chk("clr_keeps_array_data", 32'(mo[1]), 32'h5A);

      // Read and write together: performed as a write, flags error
      xfer(0, 1'b1, 1'b1, 4'd4, 8'h11, 1, "both_hi");
      chk("both_hi_err", 32'(er[0]), 32'd1);
      chk("both_hi_mout_held", 32'(mo[0]), 32'h03);
      xfer(0, 1'b1, 1'b0, 4'd4, 8'h00, 1, "both_hi_readback");
      chk("both_hi_data", 32'(mo[0]), 32'h11);
      chk("both_hi_err_sticky", 32'(er[0]), 32'd1);

      // Preload and CPU write commit to the same address on the same edge
      @(negedge clk);
      ld_en[0] = 1'b1; ld_a[0] = 4'd3; ld_d[0] = 8'h99;
      xfer(0, 1'b0, 1'b1, 4'd3, 8'h22, 1, "collide_write");
      xfer(0, 1'b1, 1'b0, 4'd3, 8'h00, 1, "collide_read");
      chk("collide_preload_wins", 32'(mo[0]), 32'h99);

      // Five wait states: abort an in-flight write with clr
      preload(2, 4'd1, 8'hA5);
      preload(2, 4'd6, 8'h3C);
      xfer(2, 1'b1, 1'b0, 4'd6, 8'h00, 6, "w5_read6");
      chk("w5_read6_data", 32'(mo[2]), 32'h3C);
      xfer(2, 1'b1, 1'b1, 4'd9, 8'h00, 6, "w5_both_hi");
      chk("w5_err_set", 32'(er[2]), 32'd1);
      @(negedge clk);
      wr[2] = 1'b1; ad[2] = 4'd1; din[2] = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      wr[2] = 1'b0;
      @(negedge clk);
      clr[2] = 1'b1;
      @(negedge clk);
      clr[2] = 1'b0;
      chk("abort_ready", 32'(rdy[2]), 32'd0);
      chk("abort_mout", 32'(mo[2]), 32'd0);
      chk("abort_err", 32'(er[2]), 32'd0);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rdy[2]) hits++;
      end
      chk("abort_no_ready", 32'(hits), 32'd0);
      xfer(2, 1'b1, 1'b0, 4'd1, 8'h00, 6, "abort_read1");
      chk("abort_write_discarded", 32'(mo[2]), 32'hA5);
      xfer(2, 1'b1, 1'b0, 4'd6, 8'h00, 6, "abort_read6");
      chk("abort_preload_intact", 32'(mo[2]), 32'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
